// File: rtl/vga_ctrl_pkg.sv
// Shared types for the VGA mode controller: config word, FSM states, auto-cycle table, colour decode.
// Pure declarations, no latency or flow control.
package vga_ctrl_pkg;

    typedef struct packed {
        logic       gray_byp;
        logic       bar_byp;
        logic [1:0] back_sel;
    } cfg_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_e;

    localparam logic [0:3][3:0] AUTO_TBL = {4'b1000, 4'b0000, 4'b1101, 4'b1111};

    // {red, green, blue} channel-enable mask; an enabled channel is driven all ones.
    function automatic logic [2:0] back_rgb_mask(input logic [1:0] sel);
        logic [2:0] m;
        m = 3'b000;
        case (sel)
            2'b00: m = 3'b000;
            2'b01: m = 3'b100;
            2'b10: m = 3'b010;
            2'b11: m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame-boundary detector: one-clk pulse, one cycle after (hc==0 && vc==V_LATCH) first appears.
// Holding the match for several clocks still yields one pulse; no backpressure.
module vga_frame_tick #(
    parameter int V_LATCH = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    output logic        frame_tick
);

    logic match;
    logic match_d;

    assign match = (hc == 11'd0) && (vc == 11'(V_LATCH));

    // match_d resets high so a match already present at reset release is not a new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_d    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            match_d    <= match;
            frame_tick <= match & ~match_d;
        end
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Frame-synchronous switch debounce/apply for the VGA path; config changes one clk after frame_tick.
// No backpressure. Optional auto-cycle mode under the AUTO_CYCLE_EN macro.
module vga_mode_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int         CD          = 12,
    parameter int         V_LATCH     = 480,
    parameter int         DEB_FRAMES  = 3,
    parameter int         STEP_FRAMES = 120,
    parameter logic [3:0] RST_CFG     = 4'b1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    sw,
    input  logic [10:0]   hc,
    input  logic [10:0]   vc,
`ifdef AUTO_CYCLE_EN
    input  logic          auto_en,
`endif
    output logic [CD-1:0] back_rgb,
    output logic          bypass_bar,
    output logic          bypass_gray,
    output logic          frame_tick,
    output logic          cfg_changed,
    output logic [15:0]   frame_cnt
);

    localparam int CH_W  = CD / 3;
    localparam int CNT_W = $clog2(DEB_FRAMES + 1);

    logic [3:0]       sw_s1;
    logic [3:0]       sw_s2;
    cfg_t             sampled;
    cfg_t             applied, applied_nxt;
    cfg_t             cand, cand_nxt;
    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       rgb_mask;

`ifdef AUTO_CYCLE_EN
    localparam int STEP_W = $clog2(STEP_FRAMES + 1);

    logic              auto_act, auto_act_nxt;
    logic [1:0]        idx, idx_nxt;
    logic [STEP_W-1:0] step, step_nxt;
`endif

    vga_frame_tick #(
        .V_LATCH (V_LATCH)
    ) u_frame_tick (
        .clk        (clk),
        .reset      (reset),
        .hc         (hc),
        .vc         (vc),
        .frame_tick (frame_tick)
    );

    assign sampled = cfg_t'(sw_s2);

    always_comb begin
        state_nxt   = state;
        cand_nxt    = cand;
        cnt_nxt     = cnt;
        applied_nxt = applied;
`ifdef AUTO_CYCLE_EN
        auto_act_nxt = auto_act;
        idx_nxt      = idx;
        step_nxt     = step;
`endif
        if (frame_tick) begin
`ifdef AUTO_CYCLE_EN
            auto_act_nxt = auto_en;
            if (auto_en) begin
                // Debounce is parked while the table drives the config.
                state_nxt = S_RUN;
                cnt_nxt   = '0;
                if (!auto_act) begin
                    idx_nxt     = 2'd0;
                    step_nxt    = '0;
                    applied_nxt = cfg_t'(AUTO_TBL[0]);
                end else if (int'(step) + 1 == STEP_FRAMES) begin
                    idx_nxt     = idx + 2'd1;
                    step_nxt    = '0;
                    applied_nxt = cfg_t'(AUTO_TBL[idx_nxt]);
                end else begin
                    step_nxt = step + 1'b1;
                end
            end else
`endif
            begin
                case (state)
                    S_RUN: begin
                        if (sampled != applied) begin
                            if (DEB_FRAMES == 1) begin
                                applied_nxt = sampled;
                            end else begin
                                cand_nxt  = sampled;
                                cnt_nxt   = CNT_W'(1);
                                state_nxt = S_PEND;
                            end
                        end
                    end
                    S_PEND: begin
                        if (sampled == applied) begin
                            state_nxt = S_RUN;
                            cnt_nxt   = '0;
                        end else if (sampled != cand) begin
                            cand_nxt = sampled;
                            cnt_nxt  = CNT_W'(1);
                        end else if (int'(cnt) + 1 == DEB_FRAMES) begin
                            applied_nxt = cand;
                            state_nxt   = S_RUN;
                            cnt_nxt     = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1       <= '0;
            sw_s2       <= '0;
            applied     <= cfg_t'(RST_CFG);
            cand        <= '0;
            state       <= S_RUN;
            cnt         <= '0;
            cfg_changed <= 1'b0;
            frame_cnt   <= '0;
`ifdef AUTO_CYCLE_EN
            auto_act    <= 1'b0;
            idx         <= '0;
            step        <= '0;
`endif
        end else begin
            sw_s1       <= sw;
            sw_s2       <= sw_s1;
            applied     <= applied_nxt;
            cand        <= cand_nxt;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cfg_changed <= (applied_nxt != applied);
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
`ifdef AUTO_CYCLE_EN
            auto_act    <= auto_act_nxt;
            idx         <= idx_nxt;
            step        <= step_nxt;
`endif
        end
    end

    assign rgb_mask    = back_rgb_mask(applied.back_sel);
    assign back_rgb    = {{CH_W{rgb_mask[2]}}, {CH_W{rgb_mask[1]}}, {CH_W{rgb_mask[0]}}};
    assign bypass_bar  = applied.bar_byp;
    assign bypass_gray = applied.gray_byp;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: directed table, reset corner cases, random frames against a streak model.
// Auto-cycle checks are compiled in with AUTO_CYCLE_EN.
module tb_vga_mode_ctrl;

    localparam int CD   = 12;
    localparam int VL   = 4;
    localparam int DEB  = 3;
    localparam int STEP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    sw;
    logic [10:0]   hc;
    logic [10:0]   vc;
    logic          auto_en;
    logic [CD-1:0] back_rgb;
    logic          bypass_bar;
    logic          bypass_gray;
    logic          frame_tick;
    logic          cfg_changed;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: applied config, streak of identical per-frame samples.
    logic [3:0]  m_applied;
    logic [3:0]  m_streak_val;
    int          m_streak;
    bit          m_auto_act;
    int          m_auto_k;
    logic [15:0] m_fcnt;
    logic [3:0]  auto_tbl [4] = '{4'b1000, 4'b0000, 4'b1101, 4'b1111};

    typedef struct {
        logic [3:0] sw;
        int         hold;
        logic [3:0] exp_cfg;
        int         exp_chg;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    vga_mode_ctrl #(
        .CD          (CD),
        .V_LATCH     (VL),
        .DEB_FRAMES  (DEB),
        .STEP_FRAMES (STEP),
        .RST_CFG     (4'b1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .hc          (hc),
        .vc          (vc),
`ifdef AUTO_CYCLE_EN
        .auto_en     (auto_en),
`endif
        .back_rgb    (back_rgb),
        .bypass_bar  (bypass_bar),
        .bypass_gray (bypass_gray),
        .frame_tick  (frame_tick),
        .cfg_changed (cfg_changed),
        .frame_cnt   (frame_cnt)
    );

    function automatic logic [11:0] rgb_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 12'h000;
            2'b01:   return 12'hF00;
            2'b10:   return 12'h0F0;
            default: return 12'h00F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cfg(input string tag, input logic [3:0] cfg);
        chk({tag, " back_rgb"}, 32'(back_rgb), 32'(rgb_of(cfg[1:0])));
        chk({tag, " bypass_bar"}, 32'(bypass_bar), 32'(cfg[2]));
        chk({tag, " bypass_gray"}, 32'(bypass_gray), 32'(cfg[3]));
    endtask

    task automatic model_reset();
        m_applied  = 4'b1000;
        m_streak   = 0;
        m_auto_act = 1'b0;
        m_auto_k   = 0;
        m_fcnt     = 16'd0;
    endtask

    task automatic model_tick(output int changed);
        logic [3:0] prev;
        prev   = m_applied;
        m_fcnt = m_fcnt + 16'd1;
        if (auto_en) begin
            m_auto_k   = m_auto_act ? m_auto_k + 1 : 0;
            m_auto_act = 1'b1;
            m_applied  = auto_tbl[(m_auto_k / STEP) % 4];
            m_streak   = 0;
        end else begin
            m_auto_act = 1'b0;
            if (m_streak > 0 && sw == m_streak_val) begin
                m_streak++;
            end else begin
                m_streak_val = sw;
                m_streak     = 1;
            end
            if (sw != m_applied && m_streak >= DEB) m_applied = sw;
        end
        changed = (m_applied != prev) ? 1 : 0;
    endtask

    // One frame: idle so sw settles through the synchronizer, then hold the boundary for 'hold' clocks.
    task automatic do_frame(input int hold, input string tag, output int ncc);
        int nft;
        int exp_chg;
        nft = 0;
        ncc = 0;
        repeat (3) @(negedge clk);
        hc = 11'd0;
        vc = 11'(VL);
        for (int i = 0; i < hold + 3; i++) begin
            @(negedge clk);
            if (frame_tick) nft++;
            if (cfg_changed) ncc++;
            if (i == hold - 1) hc = 11'd1;
        end
        model_tick(exp_chg);
        chk({tag, " frame_tick pulses"}, 32'(nft), 32'd1);
        chk({tag, " cfg_changed pulses"}, 32'(ncc), 32'(exp_chg));
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_fcnt));
        chk_cfg({tag, " model"}, m_applied);
    endtask

    task automatic do_reset(input bit hold_match, input string tag);
        int nft;
        nft   = 0;
        reset = 1'b1;
        hc    = hold_match ? 11'd0 : 11'd1;
        vc    = 11'(VL);
        repeat (2) @(negedge clk);
        model_reset();
        chk({tag, " reset frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, " reset cfg_changed"}, 32'(cfg_changed), 32'd0);
        chk({tag, " reset frame_tick"}, 32'(frame_tick), 32'd0);
        chk_cfg({tag, " reset"}, 4'b1000);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_tick) nft++;
        end
        chk({tag, " no tick at release"}, 32'(nft), 32'd0);
        hc = 11'd1;
    endtask

    initial begin
        int ncc;
        logic [3:0] auto_seq [9];

        auto_en = 1'b0;
        sw      = 4'b0000;
        hc      = 11'd1;
        vc      = 11'd0;
        reset   = 1'b0;

        tbl[0] = '{4'b0000, 4, 4'b1000, 0};
        tbl[1] = '{4'b0001, 1, 4'b1000, 0};
        tbl[2] = '{4'b0001, 2, 4'b1000, 0};
        tbl[3] = '{4'b0001, 3, 4'b0001, 1};
        tbl[4] = '{4'b1000, 1, 4'b0001, 0};
        tbl[5] = '{4'b1000, 2, 4'b0001, 0};
        tbl[6] = '{4'b0001, 1, 4'b0001, 0};
        tbl[7] = '{4'b0011, 4, 4'b0001, 0};
        tbl[8] = '{4'b0010, 1, 4'b0001, 0};
        tbl[9] = '{4'b0010, 2, 4'b0001, 0};

        do_reset(1'b1, "rst0");

        for (int i = 0; i < 10; i++) begin
            sw = tbl[i].sw;
            do_frame(tbl[i].hold, $sformatf("tbl%0d", i), ncc);
            chk_cfg($sformatf("tbl%0d const", i), tbl[i].exp_cfg);
            chk($sformatf("tbl%0d const cfg_changed", i), 32'(ncc), 32'(tbl[i].exp_chg));
        end
        sw = 4'b0010;
        do_frame(1, "apply0010", ncc);
        chk_cfg("apply0010 const", 4'b0010);
        chk("apply0010 const cfg_changed", 32'(ncc), 32'd1);

        // Reset while a candidate has two frames of history; it must not survive.
        sw = 4'b1101;
        do_frame(1, "pend1", ncc);
        do_frame(2, "pend2", ncc);
        do_reset(1'b0, "rst_pend");
        do_frame(1, "post_rst1", ncc);
        chk_cfg("post_rst1 const", 4'b1000);
        do_frame(1, "post_rst2", ncc);
        do_frame(1, "post_rst3", ncc);
        chk_cfg("post_rst3 const", 4'b1101);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) >= 7) sw = 4'($urandom_range(0, 15));
            do_frame(int'($urandom_range(1, 4)), $sformatf("rnd%0d", i), ncc);
        end

`ifdef AUTO_CYCLE_EN
        auto_seq = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1101,
                     4'b1101, 4'b1111, 4'b1111, 4'b1000};
        auto_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sw = 4'($urandom_range(0, 15));
            do_frame(int'($urandom_range(1, 3)), $sformatf("auto%0d", i), ncc);
            chk_cfg($sformatf("auto%0d const", i), auto_seq[i]);
        end
        auto_en = 1'b0;
        sw = 4'b0110;
        do_frame(1, "auto_off1", ncc);
        chk_cfg("auto_off1 const", 4'b1000);
        do_frame(2, "auto_off2", ncc);
        do_frame(1, "auto_off3", ncc);
        chk_cfg("auto_off3 const", 4'b0110);
        for (int i = 0; i < 20; i++) begin
            auto_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) >= 6) sw = 4'($urandom_range(0, 15));
            do_frame(int'($urandom_range(1, 4)), $sformatf("amix%0d", i), ncc);
        end
        auto_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
